// File: rtl/adder_arbiter.sv
// Round-robin arbiter/sequencer for one shared 4-bit ripple adder: grants, holds operands, captures result.
// Optional 8-bit saturating overflow counter on port ovf_cnt when ADDARB_OVFCNT_EN is defined.
`timescale 1ns/1ps

module adder_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       ack0,
    output logic       ack1,
    output logic [3:0] res_sum,
    output logic       res_ovf,
    output logic       busy,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    input  logic [3:0] add_sum,
    input  logic       add_ovf
`ifdef ADDARB_OVFCNT_EN
    ,
    output logic [7:0] ovf_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic       last_grant;
    logic       grant;
    logic       winner;
    logic       capture;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        winner     = last_grant;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant      = 1'b1;
                    state_next = SETTLE;
                    winner     = (req0 && req1) ? ~last_grant : req1;
                end
            end
            SETTLE:  if (cnt == 4'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        capture = (state == SETTLE) && (cnt == 4'd0);
    end

    // last_grant starts at 1 so requester 0 wins the first contested grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a      <= 4'd0;
            add_b      <= 4'd0;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            res_sum    <= 4'd0;
            res_ovf    <= 1'b0;
        end else begin
            if (grant) begin
                add_a      <= winner ? a1 : a0;
                add_b      <= winner ? b1 : b0;
                last_grant <= winner;
                cnt        <= CNT_LOAD;
            end else if (state == SETTLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            ack0 <= capture && !last_grant;
            ack1 <= capture && last_grant;
            if (capture) begin
                res_sum <= add_sum;
                res_ovf <= add_ovf;
            end
        end
    end

`ifdef ADDARB_OVFCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= 8'd0;
        end else if (capture && add_ovf && ovf_cnt != 8'hFF) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: driver pushes expected acks, monitor pops on each ack.
// Attaches a behavioural adder whose outputs are wrong until 14 ns after an operand change.
`timescale 1ns/1ps

module tb_adder_arbiter;

    localparam int S = 2;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic       ack0, ack1;
    logic [3:0] res_sum;
    logic       res_ovf;
    logic       busy;
    logic [3:0] add_a, add_b;
    logic [3:0] add_sum;
    logic       add_ovf;
`ifdef ADDARB_OVFCNT_EN
    logic [7:0] ovf_cnt;
`endif

    adder_arbiter #(.SETTLE_CYCLES(S)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .ack0    (ack0),
        .ack1    (ack1),
        .res_sum (res_sum),
        .res_ovf (res_ovf),
        .busy    (busy),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_sum (add_sum),
        .add_ovf (add_ovf)
`ifdef ADDARB_OVFCNT_EN
        ,
        .ovf_cnt (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ripple adder: shows an inverted (unresolved) value until it settles.
    always @(add_a or add_b) begin
        logic [4:0] t;
        t = {1'b0, add_a} + {1'b0, add_b};
        {add_ovf, add_sum} = ~t;
        #14;
        t = {1'b0, add_a} + {1'b0, add_b};
        {add_ovf, add_sum} = t;
    end

    typedef struct {
        int         who;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum;
        logic       ovf;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   model_last = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int who, input logic [3:0] x, input logic [3:0] y, input int at);
        exp_t e;
        int   s;
        s     = int'(x) + int'(y);
        e.who = who;
        e.a   = x;
        e.b   = y;
        e.sum = 4'(s % 16);
        e.ovf = (s > 15);
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, away from DUT updates.
    logic [3:0] last_sum;
    logic       last_ovf;
    int         busy_run;
    int         model_cnt;
    initial begin
        last_sum  = 4'd0;
        last_ovf  = 1'b0;
        busy_run  = 0;
        model_cnt = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_sum  = 4'd0;
            last_ovf  = 1'b0;
            busy_run  = 0;
            model_cnt = 0;
        end else begin
            check("ack_onehot", int'(ack0 && ack1), 0);
            if (ack0 || ack1) begin
                check("ack_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("ack_who", int'(ack1), e.who);
                    check("res_sum", int'(res_sum), int'(e.sum));
                    check("res_ovf", int'(res_ovf), int'(e.ovf));
                    check("ack_latency", cyc, e.cyc);
                    check("add_a_hold", int'(add_a), int'(e.a));
                    check("add_b_hold", int'(add_b), int'(e.b));
                    check("busy_in_done", int'(busy), 1);
                    last_sum = e.sum;
                    last_ovf = e.ovf;
                    if (e.ovf && model_cnt < 255) model_cnt++;
`ifdef ADDARB_OVFCNT_EN
                    check("ovf_cnt", int'(ovf_cnt), model_cnt);
`endif
                end
            end else begin
                check("res_sum_hold", int'(res_sum), int'(last_sum));
                check("res_ovf_hold", int'(res_ovf), int'(last_ovf));
            end
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                check("busy_len", busy_run, S + 1);
                busy_run = 0;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Assumes entry at posedge+1; returns at posedge+1 after all acks are taken.
    task automatic do_txn(input logic r0, input logic r1,
                          input logic [3:0] x0, input logic [3:0] y0,
                          input logic [3:0] x1, input logic [3:0] y1);
        int   c, first, n;
        logic s0, s1;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        req0 = r0; req1 = r1;
        c = cyc;
        first = (r0 && r1) ? (1 - model_last) : (r1 ? 1 : 0);
        if (first == 0) push(0, x0, y0, c + 1 + S);
        else            push(1, x1, y1, c + 1 + S);
        if (r0 && r1) begin
            if (first == 0) push(1, x1, y1, c + 1 + 2 * S + 2);
            else            push(0, x0, y0, c + 1 + 2 * S + 2);
            model_last = 1 - first;
        end else begin
            model_last = first;
        end
        n = 0;
        while ((req0 || req1) && n < 40) begin
            @(negedge clk);
            s0 = ack0;
            s1 = ack1;
            @(posedge clk);
            #1;
            // Operands are registered at grant, so changing them afterwards must not matter.
            if (n == 0 && (r0 ^ r1)) begin
                if (r0) begin a0 = 4'($urandom); b0 = 4'($urandom); end
                else    begin a1 = 4'($urandom); b1 = 4'($urandom); end
            end
            if (s0) begin req0 = 1'b0; a0 = 4'($urandom); b0 = 4'($urandom); end
            if (s1) begin req1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom); end
            n++;
        end
        check("txn_done", int'(req0 || req1), 0);
        if (req0 || req1) begin
            req0 = 1'b0;
            req1 = 1'b0;
            exp_q.delete();
        end
    endtask

    task automatic do_hold(input int k);
        int c, w, got, n;
        a0 = 4'($urandom); b0 = 4'($urandom);
        a1 = 4'($urandom); b1 = 4'($urandom);
        req0 = 1'b1; req1 = 1'b1;
        c = cyc;
        w = 1 - model_last;
        for (int i = 0; i < k; i++) begin
            if (w == 0) push(0, a0, b0, c + 1 + S + i * (S + 2));
            else        push(1, a1, b1, c + 1 + S + i * (S + 2));
            model_last = w;
            w = 1 - w;
        end
        got = 0;
        n   = 0;
        while (got < k && n < k * (S + 2) + 20) begin
            @(negedge clk);
            if (ack0 || ack1) got++;
            @(posedge clk);
            #1;
            n++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("hold_acks", got, k);
        if (got != k) exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        #23;
        check("rst_ack0", int'(ack0), 0);
        check("rst_ack1", int'(ack1), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sum", int'(res_sum), 0);
        check("rst_ovf", int'(res_ovf), 0);
        check("rst_add_a", int'(add_a), 0);
        check("rst_add_b", int'(add_b), 0);
        #4;
        rst_n = 1'b1;
        wait_cycles(2);

        do_txn(1'b1, 1'b0, 4'd3, 4'd5, 4'd0, 4'd0);
        wait_cycles(1);
        do_txn(1'b0, 1'b1, 4'd0, 4'd0, 4'd9, 4'd8);
        wait_cycles(2);

        // Abort a transaction mid-SETTLE; no ack may follow.
        a0 = 4'd7; b0 = 4'd6; req0 = 1'b1;
        @(posedge clk);
        #1;
        check("pre_abort_busy", int'(busy), 1);
        rst_n = 1'b0;
        req0  = 1'b0;
        #1;
        check("abort_ack0", int'(ack0), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_sum", int'(res_sum), 0);
        check("abort_add_a", int'(add_a), 0);
        check("abort_add_b", int'(add_b), 0);
        model_last = 1;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(4);

        do_txn(1'b1, 1'b1, 4'd1, 4'd2, 4'd15, 4'd15);
        wait_cycles(1);
        do_hold(6);
        wait_cycles(2);

        for (int i = 0; i < 40; i++) begin
            int p;
            p = int'($urandom_range(1, 3));
            do_txn(p[0], p[1], 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            wait_cycles(int'($urandom_range(0, 2)));
        end

`ifdef ADDARB_OVFCNT_EN
        for (int i = 0; i < 300; i++) do_txn(1'b1, 1'b0, 4'd15, 4'd1, 4'd0, 4'd0);
        wait_cycles(1);
        check("ovf_cnt_sat", int'(ovf_cnt), 255);
        do_txn(1'b0, 1'b1, 4'd0, 4'd0, 4'd2, 4'd2);
        wait_cycles(1);
        check("ovf_cnt_hold", int'(ovf_cnt), 255);
`endif

        wait_cycles(5);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
